// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared types and constants for the RAM stream reader
package ram_stream_reader_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/stream_skid_buffer.sv
// stream_skid_buffer: small FIFO that absorbs RAM read latency, head always at entry 0
module stream_skid_buffer #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic                         pop,
    output logic [DATA_WIDTH-1:0]        head,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int CW = $clog2(DEPTH+1);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic                  pop_ok;
    // shift down on pop, write the new word just above the surviving entries
    always_comb begin
        mem_d   = mem_q;
        pop_ok  = pop && (count_q != '0);
        count_d = count_q + CW'(push) - CW'(pop_ok);
        for (int i = 0; i < DEPTH; i++) begin
            if (pop_ok && i < DEPTH - 1) mem_d[i] = mem_q[i+1];
            if (push && i == int'(count_q - CW'(pop_ok))) mem_d[i] = push_data;
        end
    end
    // storage and occupancy registers, flushed to empty on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
    assign head      = mem_q[0];
    assign occupancy = count_q;
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a block of words from a 1-cycle RAM and streams them with backpressure
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    localparam int OW = $clog2(SKID_DEPTH+1);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]  beat_left_q, beat_left_d;
    logic                  inflight_q, inflight_d;
    logic [OW-1:0]         occupancy;
    logic [2:0]            load;
    logic                  pop, issue;

    stream_skid_buffer #(
        .DEPTH      (SKID_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (ram_data_out),
        .pop       (pop),
        .head      (m_data),
        .occupancy (occupancy)
    );

    assign m_valid    = occupancy != '0;
    assign pop        = m_valid && m_ready;
    assign m_last     = m_valid && (beat_left_q == LEN_WIDTH'(1));
    assign ram_addr_r = rd_ptr_q;
    // words already owed to the buffer (stored + arriving) must leave room for the new read
    assign load  = 3'(occupancy) + 3'(inflight_q);
    assign issue = (state_q == ST_RUN) && (issue_left_q != '0) && (load < 3'd2 + 3'(pop));

    // next-state, pointer/counter updates and status outputs
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        issue_left_d = issue_left_q;
        beat_left_d  = beat_left_q;
        inflight_d   = issue;
        busy         = state_q == ST_RUN;
        done         = state_q == ST_FINISH;
        case (state_q)
            ST_IDLE: if (start) begin
                rd_ptr_d     = base_addr;
                issue_left_d = length;
                beat_left_d  = length;
                state_d      = (length == '0) ? ST_FINISH : ST_RUN;
            end
            ST_RUN: begin
                if (issue) begin
                    rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
                    issue_left_d = issue_left_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    beat_left_d = beat_left_q - LEN_WIDTH'(1);
                    if (beat_left_q == LEN_WIDTH'(1)) state_d = ST_FINISH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // control registers; reset aborts any transfer without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_ptr_q     <= '0;
            issue_left_q <= '0;
            beat_left_q  <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_left_q <= issue_left_d;
            beat_left_q  <= beat_left_d;
            inflight_q   <= inflight_d;
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench with a 1-cycle registered RAM model
module tb_ram_stream_reader;
    logic        clk = 1'b0;
    logic        reset, start, m_ready;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic        busy, done, m_valid, m_last;
    logic [11:0] ram_addr_r;
    logic [7:0]  ram_data_out, m_data;
    logic [7:0]  mem [4096];
    logic [7:0]  sb [$];
    int          checks = 0;
    int          errors = 0;

    ram_stream_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_addr_r   (ram_addr_r),
        .ram_data_out (ram_data_out),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    // RAM model: registered read every cycle
    always @(posedge clk) ram_data_out <= mem[ram_addr_r];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random; exact checks cycle timing
    task automatic run_xfer(input logic [11:0] b, input int n, input int mode, input bit exact, input bit poke);
        int c, beats, dones;
        logic [11:0] a;
        logic [7:0] exp_d, prev_d;
        bit stalled;
        for (int i = 0; i < n; i++) begin
            a = b + 12'(i);
            sb.push_back(mem[a]);
        end
        start = 1'b1;
        base_addr = b;
        length = 13'(n);
        tick();
        start = 1'b0;
        c = 1;
        beats = 0;
        dones = 0;
        stalled = 1'b0;
        prev_d = '0;
        while (dones == 0 && c < n + 400) begin
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(c % 3 == 1) : 1'($urandom_range(0, 1));
            if (poke) begin
                start = logic'(c == 3);
                base_addr = b + 12'h400;
                length = 13'd7;
            end
            if (exact) begin
                checks++;
                if (m_valid !== logic'(c >= 3 && c < 3 + n)) begin
                    errors++;
                    $display("FAIL valid_timing cycle %0d got %b want %b", c, m_valid, logic'(c >= 3 && c < 3 + n));
                end
                a = b + 12'((c - 1 < n) ? c - 1 : n);
                checks++;
                if (ram_addr_r !== a) begin
                    errors++;
                    $display("FAIL addr_seq cycle %0d got %h want %h", c, ram_addr_r, a);
                end
            end
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_d) begin
                    errors++;
                    $display("FAIL stall_hold cycle %0d got v=%b d=%h want v=1 d=%h", c, m_valid, m_data, prev_d);
                end
            end
            checks++;
            if (busy !== logic'(beats < n)) begin
                errors++;
                $display("FAIL busy cycle %0d got %b want %b", c, busy, logic'(beats < n));
            end
            checks++;
            if (done !== logic'(beats == n)) begin
                errors++;
                $display("FAIL done cycle %0d got %b want %b", c, done, logic'(beats == n));
            end
            if (done === 1'b1) dones++;
            a = ram_addr_r - b - 12'(beats);
            checks++;
            if (a > 12'd2) begin
                errors++;
                $display("FAIL runahead cycle %0d got %0d want <=2", c, a);
            end
            checks++;
            if (m_last !== logic'(m_valid === 1'b1 && sb.size() == 1)) begin
                errors++;
                $display("FAIL m_last cycle %0d got %b want %b", c, m_last, logic'(m_valid === 1'b1 && sb.size() == 1));
            end
            if (m_valid === 1'b1 && sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_beat cycle %0d got data %h want none", c, m_data);
            end else if (m_valid === 1'b1 && m_ready) begin
                exp_d = sb.pop_front();
                beats++;
                checks++;
                if (m_data !== exp_d) begin
                    errors++;
                    $display("FAIL beat_data beat %0d got %h want %h", beats, m_data, exp_d);
                end
            end
            stalled = m_valid === 1'b1 && !m_ready;
            prev_d = m_data;
            tick();
            c++;
        end
        checks++;
        if (dones != 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL completion got dones=%0d left=%0d want dones=1 left=0", dones, sb.size());
        end
        sb.delete();
        start = 1'b0;
        m_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, m_valid, m_last, ram_addr_r, m_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b %h %h want all zero", busy, done, m_valid, m_last, ram_addr_r, m_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        mem[12'h010] = 8'hA0;
        mem[12'h011] = 8'hA1;
        mem[12'h012] = 8'hA2;
        mem[12'h013] = 8'hA3;
        run_xfer(12'h010, 4, 0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_xfer(12'h010, 4, 1, 1'b0, 1'b0);
        run_xfer(12'h080, 20, 2, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_xfer(12'hFFE, 4, 0, 1'b1, 1'b0);
    endtask

    task automatic test_zero_length();
        run_xfer(12'h055, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic test_restart_ignored();
        run_xfer(12'h010, 4, 0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        start = 1'b1;
        base_addr = 12'h200;
        length = 13'd8;
        tick();
        start = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, m_valid, m_last, ram_addr_r, m_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid got %b%b%b%b %h %h want all zero", busy, done, m_valid, m_last, ram_addr_r, m_data);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({busy, done, m_valid} !== 3'b000) begin
                errors++;
                $display("FAIL after_reset cycle %0d got %b want 000", c, {busy, done, m_valid});
            end
        end
        m_ready = 1'b0;
        run_xfer(12'h300, 5, 0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_xfer(12'h400, 3, 0, 1'b1, 1'b0);
        run_xfer(12'h403, 3, 2, 1'b0, 1'b0);
    endtask

    task automatic test_full_ram();
        run_xfer(12'h123, 4096, 0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        m_ready = 1'b0;
        base_addr = '0;
        length = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 4);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_full_ram();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
